// File: rtl/block_dispatcher.sv
// -----------------------------------------------------------------------------
// block_dispatcher
//
// Kernel-level thread-block scheduler. An accepted start latches the kernel
// configuration. Blocks 0..num_blocks-1 are then handed out to free compute
// cores, at most one per cycle, and the lowest-index free core is chosen first.
// Per-core busy state is cleared by the cores' done pulses. The kernel is
// complete when every dispatched block has retired.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   rst_n          : asynchronous active-low reset
//   start          : launch pulse, accepted only while idle or done
//   kernel_config  : num_blocks, num_warps_per_block, base addresses
//   core_start     : per-core 1-cycle pulse, core i accepts a block
//   core_block_id  : per-core block index, valid with core_start[i], held after
//   core_warps     : latched num_warps_per_block, shared by all cores
//   core_done      : per-core 1-cycle pulse, core i retired its block
//   busy           : kernel in flight (dispatching or draining)
//   done           : every block of the last kernel has retired
// -----------------------------------------------------------------------------
package block_dispatcher_pkg;

    localparam int DATA_WIDTH = 32;

    typedef struct packed {
        logic [31:0]           base_instr_addr;
        logic [31:0]           base_data_addr;
        logic [DATA_WIDTH-1:0] num_warps_per_block;
        logic [31:0]           num_blocks;
    } kernel_config_t;

endpackage

module block_dispatcher
    import block_dispatcher_pkg::*;
#(
    parameter int NUM_CORES = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  kernel_config_t                       kernel_config,
    output logic [NUM_CORES-1:0]                 core_start,
    output logic [NUM_CORES-1:0][DATA_WIDTH-1:0] core_block_id,
    output logic [DATA_WIDTH-1:0]                core_warps,
    input  logic [NUM_CORES-1:0]                 core_done,
    output logic                                 busy,
    output logic                                 done
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Lowest set bit of req as a one-hot vector (all zero when req is empty).
    function automatic logic [NUM_CORES-1:0] lowest_onehot(input logic [NUM_CORES-1:0] req);
        logic [NUM_CORES-1:0] res;
        res = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req[i]) begin
                res    = '0;
                res[i] = 1'b1;
            end
        end
        return res;
    endfunction

    // Binary index of the lowest set bit of req (zero when req is empty).
    function automatic logic [IDX_W-1:0] lowest_index(input logic [NUM_CORES-1:0] req);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = i[IDX_W-1:0];
            end
        end
        return idx;
    endfunction

    // Number of set bits, widened to the counter width.
    function automatic logic [31:0] popcount(input logic [NUM_CORES-1:0] v);
        logic [31:0] cnt;
        cnt = 32'd0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cnt = cnt + {31'd0, v[i]};
        end
        return cnt;
    endfunction

    // Registered state
    state_t                               state_r;
    logic                                 busy_r;
    logic                                 done_r;
    logic [31:0]                          num_blocks_r;
    logic [DATA_WIDTH-1:0]                core_warps_r;
    logic [31:0]                          dispatched_r;
    logic [31:0]                          retired_r;
    logic [NUM_CORES-1:0]                 core_busy_r;
    logic [NUM_CORES-1:0]                 core_start_r;
    logic [NUM_CORES-1:0][DATA_WIDTH-1:0] core_block_id_r;

    // Combinational helpers
    state_t               next_state_s;
    logic                 launch_s;
    logic                 do_dispatch_s;
    logic [NUM_CORES-1:0] free_s;
    logic [NUM_CORES-1:0] sel_onehot_s;
    logic [IDX_W-1:0]     sel_idx_s;
    logic [NUM_CORES-1:0] valid_done_s;
    logic [31:0]          dispatched_next_s;
    logic [31:0]          retired_next_s;
    logic                 unused_cfg_s;

    // The base addresses travel with the config but are consumed by the cores.
    assign unused_cfg_s = ^{kernel_config.base_instr_addr, kernel_config.base_data_addr};

    // Core selection, retire accounting and next-state decode.
    always_comb begin
        launch_s     = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        // Selection uses the pre-edge busy mask, so a core retiring this cycle
        // becomes eligible only on the following cycle.
        free_s       = ~core_busy_r;
        sel_onehot_s = lowest_onehot(free_s);
        sel_idx_s    = lowest_index(free_s);
        do_dispatch_s = (state_r == ST_DISPATCH) && (dispatched_r < num_blocks_r) && (|free_s);
        dispatched_next_s = dispatched_r + (do_dispatch_s ? 32'd1 : 32'd0);
        // Done pulses from idle cores are spurious and dropped here.
        valid_done_s   = core_done & core_busy_r;
        retired_next_s = retired_r + popcount(valid_done_s);

        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (launch_s) begin
                    next_state_s = (kernel_config.num_blocks == 32'd0) ? ST_DONE : ST_DISPATCH;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_DISPATCH: begin
                if (dispatched_next_s == num_blocks_r) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_DISPATCH;
                end
            end
            ST_DRAIN: begin
                // Post-update count, so the final done pulse completes the kernel on its own edge.
                if (retired_next_s == num_blocks_r) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and the status outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == ST_DISPATCH) || (next_state_s == ST_DRAIN);
            done_r  <= (next_state_s == ST_DONE);
        end
    end

    // Kernel configuration latch and the dispatch / retire counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_blocks_r <= 32'd0;
            core_warps_r <= '0;
            dispatched_r <= 32'd0;
            retired_r    <= 32'd0;
        end else if (launch_s) begin
            num_blocks_r <= kernel_config.num_blocks;
            core_warps_r <= kernel_config.num_warps_per_block;
            dispatched_r <= 32'd0;
            retired_r    <= 32'd0;
        end else begin
            dispatched_r <= dispatched_next_s;
            retired_r    <= retired_next_s;
        end
    end

    // Per-core busy mask, start pulses and block index hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_busy_r     <= '0;
            core_start_r    <= '0;
            core_block_id_r <= '0;
        end else begin
            core_busy_r  <= (core_busy_r & ~valid_done_s) | (do_dispatch_s ? sel_onehot_s : '0);
            core_start_r <= do_dispatch_s ? sel_onehot_s : '0;
            if (do_dispatch_s) begin
                core_block_id_r[sel_idx_s] <= dispatched_r;
            end
        end
    end

    assign core_start    = core_start_r;
    assign core_block_id = core_block_id_r;
    assign core_warps    = core_warps_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule
